// File: rtl/block_arb_pkg.sv
// block_arb_pkg: shared defaults, queued-entry layout and FSM encoding for the block-state arbiter
package block_arb_pkg;
  localparam int LINE_WIDTH_DEF = 13;
  localparam int ENTRY_FLAGS = 2;
  typedef enum logic {IDLE, DRAIN} state_t;
  // a queued entry is {shift, write, data[lw-1:0]}
  function automatic int entry_width(input int lw);
    return lw + ENTRY_FLAGS;
  endfunction
endpackage

// File: rtl/block_cmd_fifo.sv
// block_cmd_fifo: synchronous FIFO with registered full/empty, occupancy and flush
module block_cmd_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  logic [LW-1:0] level_n;
  always_comb begin
    do_push = push & !full;
    do_pop = pop & !empty;
    level_n = level + LW'(do_push) - LW'(do_pop);
  end
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (rst | flush) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      level <= level_n;
      full <= level_n == LW'(DEPTH);
      empty <= level_n == '0;
    end
endmodule

// File: rtl/block_state_arb.sv
// block_state_arb: shares block_state between the painter (zero latency, top priority)
// and SPI line ops queued and drained only in blanking or while stopped, under a per-frame budget
module block_state_arb
  import block_arb_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OPS_PER_BLANK = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic blank,
  input  logic frame_pulse,
  input  logic game_stopped,
  input  logic reset_req,
  input  logic pnt_next,
  input  logic pnt_write,
  input  logic [LINE_WIDTH-1:0] pnt_line,
  input  logic spi_shift,
  input  logic spi_write,
  input  logic [LINE_WIDTH-1:0] spi_line,
  output logic spi_ready,
  output logic st_next_line,
  output logic st_write_line,
  output logic [LINE_WIDTH-1:0] st_new_line,
  output logic st_reset,
  output logic busy,
  output logic overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int EW = entry_width(LINE_WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(MAX_OPS_PER_BLANK+1);
  localparam logic [CW-1:0] MAX_OPS = CW'(MAX_OPS_PER_BLANK);
  state_t state;
  logic [CW-1:0] ops_cnt, ops_n;
  logic [EW-1:0] head;
  logic full, empty, req, push, pop, pnt, win, drop, go_idle, quiet;
  always_comb begin
    req = spi_shift | spi_write;
    pnt = pnt_next | pnt_write;
    win = blank | game_stopped;
    quiet = rst | reset_req;
    spi_ready = !rst & !full;
    push = req & spi_ready & !reset_req;
    drop = req & full & !reset_req;
    pop = !quiet & !pnt & state == DRAIN & !empty & ops_cnt < MAX_OPS;
    ops_n = frame_pulse ? '0 : ops_cnt + CW'(pop);
    // leave DRAIN when the queue runs dry this edge, the window closes, or the budget is spent
    go_idle = !win | ops_n >= MAX_OPS | (fifo_level + LW'(push) == LW'(pop));
    st_reset = !rst & reset_req;
    st_next_line = !quiet & (pnt ? pnt_next : pop & head[EW-1]);
    st_write_line = !quiet & (pnt ? pnt_write : pop & head[EW-2]);
    st_new_line = quiet ? '0 : pnt ? pnt_line : pop ? head[LINE_WIDTH-1:0] : '0;
    busy = state == DRAIN;
  end
  block_cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(reset_req),
    .push(push),
    .pop(pop),
    .din({spi_shift, spi_write, spi_line}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ops_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ops_cnt <= ops_n;
      overflow <= overflow | drop;
      state <= reset_req ? IDLE
             : state == IDLE ? ((win & !empty & ops_cnt < MAX_OPS) ? DRAIN : IDLE)
             : (go_idle ? IDLE : DRAIN);
    end
endmodule

// File: tb/tb_block_state_arb.sv
// tb_block_state_arb: scoreboard bench; driver queues expected SPI ops, negedge monitor pops and compares
module tb_block_state_arb;
  localparam int LW = 13;
  localparam int DEPTH = 4;
  localparam int MAX = 3;
  logic clk = 0, rst = 1, blank = 0, frame_pulse = 0, game_stopped = 0, reset_req = 0;
  logic pnt_next = 0, pnt_write = 0, spi_shift = 0, spi_write = 0;
  logic [LW-1:0] pnt_line = '0, spi_line = '0;
  logic spi_ready, st_next_line, st_write_line, st_reset, busy, overflow;
  logic [LW-1:0] st_new_line;
  logic [2:0] fifo_level;
  logic [LW+1:0] exp_q[$];
  bit exp_ovf = 0, prev_win = 0;
  int fcount = 0, issues = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;

  block_state_arb #(.LINE_WIDTH(LW), .FIFO_DEPTH(DEPTH), .MAX_OPS_PER_BLANK(MAX)) dut (
    .clk(clk), .rst(rst), .blank(blank), .frame_pulse(frame_pulse), .game_stopped(game_stopped),
    .reset_req(reset_req), .pnt_next(pnt_next), .pnt_write(pnt_write), .pnt_line(pnt_line),
    .spi_shift(spi_shift), .spi_write(spi_write), .spi_line(spi_line), .spi_ready(spi_ready),
    .st_next_line(st_next_line), .st_write_line(st_write_line), .st_new_line(st_new_line),
    .st_reset(st_reset), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every SPI issue must match the oldest accepted request, inside the window and budget
  always @(negedge clk) begin
    logic [LW+1:0] got, e;
    got = {st_next_line, st_write_line, st_new_line};
    if (rst) begin
      chk("rst_ready", spi_ready, 0);
      chk("rst_st", {st_reset, got}, 0);
      prev_win = 0;
      fcount = 0;
    end else begin
      chk("st_reset", st_reset, reset_req);
      if (reset_req) chk("rr_quiet", got, 0);
      else if (pnt_next | pnt_write) chk("painter", got, {pnt_next, pnt_write, pnt_line});
      else if (st_next_line | st_write_line) begin
        issues++;
        if (exp_q.size() == 0) chk("spurious_issue", got, 0);
        else begin
          e = exp_q.pop_front();
          chk("spi_issue", got, e);
        end
        chk("issue_window", prev_win, 1);
        chk("issue_budget", fcount < MAX, 1);
        fcount++;
      end else chk("idle_st", st_new_line, 0);
      if (frame_pulse) fcount = 0;
      prev_win = blank | game_stopped;
    end
  end

  task automatic tick(input logic pn, pw, input logic [LW-1:0] pl, input logic ss, sw,
                      input logic [LW-1:0] sl, input logic rr, b, gs, fp);
    @(posedge clk); #1;
    chk("level", fifo_level, exp_q.size());
    chk("ready", spi_ready, exp_q.size() < DEPTH);
    chk("overflow", overflow, exp_ovf);
    pnt_next = pn; pnt_write = pw; pnt_line = pl;
    spi_shift = ss; spi_write = sw; spi_line = sl;
    reset_req = rr; blank = b; game_stopped = gs; frame_pulse = fp;
    if (rr) exp_q.delete();
    else if (ss | sw) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({ss, sw, sl});
      else exp_ovf = 1;
    end
    @(negedge clk); #1;
  endtask

  task automatic push(input logic ss, sw, input logic [LW-1:0] d, input logic b, gs);
    tick(0, 0, '0, ss, sw, d, 0, b, gs, 0);
  endtask

  task automatic idle(input logic b, input int n);
    repeat (n) tick(0, 0, '0, 0, 0, '0, 0, b, 0, 0);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1;
    {blank, frame_pulse, game_stopped, reset_req, pnt_next, pnt_write, spi_shift, spi_write} = '0;
    pnt_line = '0; spi_line = '0;
    exp_q.delete();
    exp_ovf = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int i0;
    do_reset;
    // queued writes wait for blank, then issue back to back
    for (int i = 1; i <= 3; i++) push(0, 1, LW'(i), 0, 0);
    idle(0, 1);
    chk("t1_level", fifo_level, 3);
    i0 = issues;
    idle(1, 1);
    chk("t1_t0", issues, i0);
    idle(1, 1);
    chk("t1_t1", issues, i0 + 1);
    idle(1, 2);
    chk("t1_t3", issues, i0 + 3);
    chk("t1_busy3", busy, 1);
    idle(1, 1);
    chk("t1_busy4", busy, 0);
    // painter pre-empts a drain without consuming the head
    do_reset;
    for (int i = 0; i < 3; i++) push(1, 1, LW'(16'h0100 + i), 0, 0);
    i0 = issues;
    idle(1, 2);
    tick(1, 1, 13'h1ABC, 0, 0, '0, 0, 1, 0, 0);
    chk("t2_hold", issues, i0 + 1);
    chk("t2_level", fifo_level, 2);
    idle(1, 2);
    chk("t2_after", issues, i0 + 3);
    // overflow on a push into a full queue, sticky until rst
    do_reset;
    for (int i = 0; i < 5; i++) push(0, 1, LW'(16'h0010 + i), 0, 0);
    idle(0, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_level", fifo_level, 4);
    idle(1, 6);
    chk("t3_sticky", overflow, 1);
    // per-frame budget, resumed by frame_pulse
    do_reset;
    for (int i = 0; i < 4; i++) push(1, 0, LW'(16'h0A00 + i), 0, 0);
    i0 = issues;
    idle(1, 8);
    chk("t4_budget", issues, i0 + 3);
    chk("t4_level", fifo_level, 1);
    chk("t4_busy", busy, 0);
    tick(0, 0, '0, 0, 0, '0, 0, 1, 0, 1);
    idle(1, 4);
    chk("t4_resume", issues, i0 + 4);
    chk("t4_empty", fifo_level, 0);
    // reset_req mid-drain flushes queue, keeps overflow
    do_reset;
    for (int i = 0; i < 5; i++) push(0, 1, LW'(16'h0200 + i), 0, 0);
    i0 = issues;
    idle(1, 2);
    tick(0, 0, '0, 0, 0, '0, 1, 1, 0, 0);
    chk("t5_noissue", issues, i0 + 1);
    idle(1, 1);
    chk("t5_busy", busy, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ovf", overflow, 1);
    // game_stopped drains outside blank; combined shift+write entry
    do_reset;
    i0 = issues;
    push(1, 1, 13'h0FFF, 0, 1);
    tick(0, 0, '0, 0, 0, '0, 0, 0, 1, 0);
    chk("t6_wait", issues, i0);
    tick(0, 0, '0, 0, 0, '0, 0, 0, 1, 0);
    chk("t6_issue", issues, i0 + 1);
    // randomized traffic
    do_reset;
    begin
      logic b, pn, pw, ss, sw;
      b = 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 7) == 0) b = !b;
        pn = 0; pw = 0; ss = 0; sw = 0;
        if ($urandom_range(0, 3) == 0) begin
          pn = 1'($urandom); pw = !pn | 1'($urandom);
        end
        if ($urandom_range(0, 1) == 0) begin
          ss = 1'($urandom); sw = !ss | 1'($urandom);
        end
        tick(pn, pw, LW'($urandom), ss, sw, LW'($urandom), $urandom_range(0, 59) == 0,
             b, $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0);
      end
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++)
      tick(0, 0, '0, 0, 0, '0, 0, 1, 0, c % 8 == 0);
    chk("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
